// File: rtl/ddmtd_meas_ctrl.sv
// -----------------------------------------------------------------------------
// ddmtd_meas_ctrl
//
// Sequences one DDMTD phase measurement run in the DDMTD sampling clock domain.
// A run:
//   1. holds both samplers in reset,
//   2. waits for them to settle,
//   3. measures 2^n_avg phase tags, one per A/B edge pair,
//   4. reports the summed tags and their average.
// A tag is the number of DDMTD cycles from a rising edge of the sampled
// reference clock (A) to the next rising edge of the sampled target clock (B).
//
// Ports
//   clk_ddmtd_i      DDMTD sampling clock (only clock of the block)
//   rst_ddmtdclk_i   synchronous, active-high reset
//   start_i          one-cycle run request, honoured only when idle
//   n_avg_i          log2 of tags per run, captured at start and clamped
//                    to MAX_AVG_LOG2
//   clk_a_sampled_i  sampled reference clock from sampler A
//   clk_b_sampled_i  sampled target clock from sampler B
//   sampler_rst_n_o  active-low reset to both samplers
//   busy_o           run in progress (from the cycle after start up to and
//                    including the done cycle)
//   done_o           one-cycle end-of-run pulse
//   err_o            run ended on a missing-edge timeout
//   phase_sum_o      accumulated tag sum (partial if err_o)
//   phase_avg_o      phase_sum_o >> captured n_avg, updated with done_o
// -----------------------------------------------------------------------------
module ddmtd_meas_ctrl #(
   parameter int TAG_W         = 16,
   parameter int MAX_AVG_LOG2  = 8,
   parameter int RST_CYCLES    = 4,
   parameter int SETTLE_CYCLES = 16
) (
   input  logic                          clk_ddmtd_i,
   input  logic                          rst_ddmtdclk_i,
   input  logic                          start_i,
   input  logic [3:0]                    n_avg_i,
   input  logic                          clk_a_sampled_i,
   input  logic                          clk_b_sampled_i,
   output logic                          sampler_rst_n_o,
   output logic                          busy_o,
   output logic                          done_o,
   output logic                          err_o,
   output logic [TAG_W+MAX_AVG_LOG2-1:0] phase_sum_o,
   output logic [TAG_W-1:0]              phase_avg_o
);

   localparam int SUM_W   = TAG_W + MAX_AVG_LOG2;
   localparam int CNT_W   = MAX_AVG_LOG2 + 1;
   localparam int SEQ_MAX = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
   localparam int SEQ_W   = $clog2(SEQ_MAX + 1);

   localparam logic [SEQ_W-1:0] RST_LAST    = SEQ_W'(RST_CYCLES - 1);
   localparam logic [SEQ_W-1:0] SETTLE_LAST = SEQ_W'(SETTLE_CYCLES - 1);
   localparam logic [3:0]       MAX_N       = 4'(MAX_AVG_LOG2);

   // The timeout fires in the cycle whose counter value is 2^TAG_W-2, i.e. as
   // the counter would reach 2^TAG_W-1. A B edge in that same cycle still
   // yields tag 2^TAG_W-1, so every tag fits in TAG_W bits.
   localparam logic [TAG_W-1:0] TMO_LAST = {{(TAG_W-1){1'b1}}, 1'b0};

   typedef enum logic [2:0] {
      S_IDLE,
      S_SRST,
      S_SETTLE,
      S_ARM_A,
      S_WAIT_B,
      S_NEXT,
      S_DONE
   } state_t;

   state_t             state_q,    state_d;
   logic [SEQ_W-1:0]   seq_cnt_q,  seq_cnt_d;   // SRST / SETTLE duration
   logic [TAG_W-1:0]   tag_cnt_q,  tag_cnt_d;   // tag and timeout counter
   logic [TAG_W-1:0]   tag_q,      tag_d;
   logic [CNT_W-1:0]   meas_cnt_q, meas_cnt_d;
   logic [3:0]         n_avg_q,    n_avg_d;
   logic [SUM_W-1:0]   sum_q,      sum_d;
   logic [TAG_W-1:0]   avg_q,      avg_d;
   logic               err_q,      err_d;
   logic               prev_a_q,   prev_a_d;
   logic               prev_b_q,   prev_b_d;
   logic               srst_n_q,   srst_n_d;

   logic edge_a;
   logic edge_b;

   assign edge_a = clk_a_sampled_i & ~prev_a_q;
   assign edge_b = clk_b_sampled_i & ~prev_b_q;

   // NOTE: every signal written here gets a default first, so no path through
   // the case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_d    = state_q;
      seq_cnt_d  = seq_cnt_q;
      tag_cnt_d  = tag_cnt_q;
      tag_d      = tag_q;
      meas_cnt_d = meas_cnt_q;
      n_avg_d    = n_avg_q;
      sum_d      = sum_q;
      avg_d      = avg_q;
      err_d      = err_q;
      prev_a_d   = clk_a_sampled_i;
      prev_b_d   = clk_b_sampled_i;

      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               state_d    = S_SRST;
               seq_cnt_d  = '0;
               meas_cnt_d = '0;
               sum_d      = '0;
               avg_d      = '0;
               err_d      = 1'b0;
               n_avg_d    = (n_avg_i > MAX_N) ? MAX_N : n_avg_i;
            end
         end

         S_SRST: begin
            // Holding prev high hides the edge a sampler produces when its
            // output comes out of reset.
            prev_a_d = 1'b1;
            prev_b_d = 1'b1;
            if (seq_cnt_q == RST_LAST) begin
               state_d   = S_SETTLE;
               seq_cnt_d = '0;
            end else begin
               seq_cnt_d = seq_cnt_q + 1'b1;
            end
         end

         S_SETTLE: begin
            prev_a_d = 1'b1;
            prev_b_d = 1'b1;
            if (seq_cnt_q == SETTLE_LAST) begin
               state_d   = S_ARM_A;
               tag_cnt_d = '0;
            end else begin
               seq_cnt_d = seq_cnt_q + 1'b1;
            end
         end

         S_ARM_A: begin
            if (edge_a && edge_b) begin
               // Coincident edges: zero phase, no need to wait for B.
               tag_d   = '0;
               state_d = S_NEXT;
            end else if (edge_a) begin
               tag_cnt_d = '0;
               state_d   = S_WAIT_B;
            end else if (tag_cnt_q == TMO_LAST) begin
               err_d   = 1'b1;
               state_d = S_DONE;
            end else begin
               tag_cnt_d = tag_cnt_q + 1'b1;
            end
         end

         S_WAIT_B: begin
            if (edge_b) begin
               // Counter is 0 in the first cycle after the A edge, so +1
               // gives the A-to-B distance in cycles.
               tag_d   = tag_cnt_q + 1'b1;
               state_d = S_NEXT;
            end else if (tag_cnt_q == TMO_LAST) begin
               err_d   = 1'b1;
               state_d = S_DONE;
            end else begin
               tag_cnt_d = tag_cnt_q + 1'b1;
            end
         end

         S_NEXT: begin
            sum_d      = sum_q + SUM_W'(tag_q);
            meas_cnt_d = meas_cnt_q + 1'b1;
            if (meas_cnt_d == (CNT_W'(1) << n_avg_q)) begin
               state_d = S_DONE;
            end else begin
               tag_cnt_d = '0;
               state_d   = S_ARM_A;
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      // The average is loaded on the transition into DONE (normal end or
      // timeout), so it is valid in the same cycle as done_o.
      if (state_d == S_DONE && state_q != S_DONE) begin
         avg_d = TAG_W'(sum_d >> n_avg_q);
      end

      // Registered from the next state: low exactly while state_q is SRST.
      srst_n_d = (state_d != S_SRST);
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values computed above.
   always_ff @(posedge clk_ddmtd_i) begin
      if (rst_ddmtdclk_i) begin
         state_q    <= S_IDLE;
         seq_cnt_q  <= '0;
         tag_cnt_q  <= '0;
         tag_q      <= '0;
         meas_cnt_q <= '0;
         n_avg_q    <= '0;
         sum_q      <= '0;
         avg_q      <= '0;
         err_q      <= 1'b0;
         prev_a_q   <= 1'b1;
         prev_b_q   <= 1'b1;
         srst_n_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         seq_cnt_q  <= seq_cnt_d;
         tag_cnt_q  <= tag_cnt_d;
         tag_q      <= tag_d;
         meas_cnt_q <= meas_cnt_d;
         n_avg_q    <= n_avg_d;
         sum_q      <= sum_d;
         avg_q      <= avg_d;
         err_q      <= err_d;
         prev_a_q   <= prev_a_d;
         prev_b_q   <= prev_b_d;
         srst_n_q   <= srst_n_d;
      end
   end

   assign sampler_rst_n_o = srst_n_q;
   assign busy_o          = (state_q != S_IDLE);
   assign done_o          = (state_q == S_DONE);
   assign err_o           = err_q;
   assign phase_sum_o     = sum_q;
   assign phase_avg_o     = avg_q;

endmodule

// File: tb/tb_ddmtd_meas_ctrl.sv
// -----------------------------------------------------------------------------
// tb_ddmtd_meas_ctrl
//
// Drives measurement runs with directed and random A-to-B delays.
// The expected result of each run is pushed when its stimulus is issued:
//   sum of delays, sum >> n, error flag.
// A negedge monitor pops that entry whenever done_o is seen and compares it.
// TAG_W is 8 so that the missing-edge timeout is reachable.
// -----------------------------------------------------------------------------
module tb_ddmtd_meas_ctrl;

   localparam int TAG_W         = 8;
   localparam int MAX_AVG_LOG2  = 8;
   localparam int RST_CYCLES    = 4;
   localparam int SETTLE_CYCLES = 16;
   localparam int SUM_W         = TAG_W + MAX_AVG_LOG2;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [3:0]       n_avg;
   logic             a;
   logic             b;
   logic             sampler_rst_n;
   logic             busy;
   logic             done;
   logic             err;
   logic [SUM_W-1:0] phase_sum;
   logic [TAG_W-1:0] phase_avg;

   always #5 clk = ~clk;

   ddmtd_meas_ctrl #(
      .TAG_W        (TAG_W),
      .MAX_AVG_LOG2 (MAX_AVG_LOG2),
      .RST_CYCLES   (RST_CYCLES),
      .SETTLE_CYCLES(SETTLE_CYCLES)
   ) dut (
      .clk_ddmtd_i    (clk),
      .rst_ddmtdclk_i (rst),
      .start_i        (start),
      .n_avg_i        (n_avg),
      .clk_a_sampled_i(a),
      .clk_b_sampled_i(b),
      .sampler_rst_n_o(sampler_rst_n),
      .busy_o         (busy),
      .done_o         (done),
      .err_o          (err),
      .phase_sum_o    (phase_sum),
      .phase_avg_o    (phase_avg)
   );

   typedef struct {
      int sum;
      int avg;
      int err;
   } exp_t;

   exp_t exp_q[$];
   int   dlist[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   rst_low_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Waits for done_o at negedges; returns the number of negedges seen.
   task automatic wait_done(input int limit, output int cycles);
      cycles = 0;
      do begin
         @(negedge clk);
         cycles++;
      end while (!done && cycles < limit);
      if (!done) begin
         n_vec++;
         n_err++;
         $display("FAIL done_wait: got no done_o, expected one within %0d cycles", limit);
      end
      @(posedge clk);
      #1;
   endtask

   // Monitor: scoreboard pop on every done_o pulse.
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         rst_low_cnt = 0;
      end else begin
         if (!busy) rst_low_cnt = 0;
         else if (!sampler_rst_n) rst_low_cnt++;
         if (done) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_done: got done_o=1, expected none (t=%0t)", $time);
            end else begin
               e = exp_q.pop_front();
               check("phase_sum", 32'(phase_sum), e.sum);
               check("phase_avg", 32'(phase_avg), e.avg);
               check("err", 32'(err), e.err);
               check("srst_len", rst_low_cnt, RST_CYCLES);
            end
         end
      end
   end

   // One run. Delays come from dlist when directed, otherwise random.
   // tmo_idx >= 0 leaves B low for that measurement to force a timeout.
   task automatic run(input logic [3:0] n, input int tmo_idx, input bit directed);
      int nn;
      int m;
      int sum;
      int d;
      int cycles;
      exp_t e;
      nn  = (n > MAX_AVG_LOG2) ? MAX_AVG_LOG2 : int'(n);
      m   = 1 << nn;
      sum = 0;
      n_avg = n;
      start = 1'b1;
      cyc(1);
      start = 1'b0;
      n_avg = 4'($urandom);        // captured at start; later values must not matter
      cyc(5);
      start = 1'b1;                // ignored: run already in SRST
      cyc(1);
      start = 1'b0;
      cyc(25);
      for (int i = 0; i < m; i++) begin
         if (i == tmo_idx) begin
            e = '{sum: sum, avg: sum >> nn, err: 1};
            exp_q.push_back(e);
            a = 1'b1;
            wait_done(400, cycles);
            // One ARM_A cycle, 255 WAIT_B cycles, then the DONE cycle.
            check("tmo_latency", cycles, 257);
            a = 1'b0;
            cyc(3);
            return;
         end
         d = directed ? dlist[i] : int'($urandom_range(0, 30));
         sum += d;
         if (i == m - 1) begin
            e = '{sum: sum, avg: sum >> nn, err: 0};
            exp_q.push_back(e);
         end
         a = 1'b1;
         if (d == 0) b = 1'b1;
         cyc(d);
         b = 1'b1;
         cyc(1);
         a = 1'b0;
         b = 1'b0;
         if (i == m - 1) begin
            wait_done(40, cycles);
         end else begin
            if (i == 1) start = 1'b1;   // ignored: run in progress
            cyc(1);
            start = 1'b0;
            cyc(2);
         end
      end
      cyc(2);
   endtask

   initial begin
      int cycles;
      rst   = 1'b1;
      start = 1'b0;
      n_avg = '0;
      a     = 1'b0;
      b     = 1'b0;
      cyc(3);
      check("rst_srst_n", 32'(sampler_rst_n), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_err", 32'(err), 0);
      check("rst_sum", 32'(phase_sum), 0);
      check("rst_avg", 32'(phase_avg), 0);
      rst = 1'b0;
      cyc(1);
      check("post_rst_srst_n", 32'(sampler_rst_n), 1);
      cyc(2);
      check("idle_busy", 32'(busy), 0);

      // Single tag of 5.
      dlist = '{5};
      run(4'd0, -1, 1'b1);
      // Four tags 10,12,10,12 -> 44 / 11.
      dlist = '{10, 12, 10, 12};
      run(4'd2, -1, 1'b1);
      // Coincident edges -> 0.
      dlist = '{0};
      run(4'd0, -1, 1'b1);
      // Timeout on the first measurement and after two completed ones.
      run(4'd0, 0, 1'b0);
      dlist = '{7, 9, 0, 0};
      run(4'd2, 2, 1'b1);
      // Random runs.
      for (int r = 0; r < 6; r++) run(4'($urandom_range(0, 4)), -1, 1'b0);
      run(4'd3, int'($urandom_range(0, 7)), 1'b0);
      // Clamped to 256 tags.
      run(4'd15, -1, 1'b0);

      // Reset in WAIT_B after one completed tag: aborts with no done_o.
      n_avg = 4'd1;
      start = 1'b1;
      cyc(1);
      start = 1'b0;
      cyc(30);
      a = 1'b1;
      cyc(6);
      b = 1'b1;
      cyc(1);
      a = 1'b0;
      b = 1'b0;
      cyc(3);
      check("mid_run_sum", 32'(phase_sum), 6);
      a = 1'b1;
      cyc(3);
      rst = 1'b1;
      cyc(1);
      check("abort_srst_n", 32'(sampler_rst_n), 0);
      check("abort_busy", 32'(busy), 0);
      check("abort_done", 32'(done), 0);
      check("abort_err", 32'(err), 0);
      check("abort_sum", 32'(phase_sum), 0);
      check("abort_avg", 32'(phase_avg), 0);
      cyc(1);
      rst = 1'b0;
      a   = 1'b0;
      cyc(1);
      check("abort_rel_srst_n", 32'(sampler_rst_n), 1);
      cyc(40);
      check("abort_busy_later", 32'(busy), 0);

      // Normal run after the abort.
      dlist = '{3, 20};
      run(4'd1, -1, 1'b1);

      cyc(5);
      check("queue_drained", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no end of test, expected finish before 1000000 ns");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/ddmtd_meas_ctrl.md
DDMTD_MEAS_CTRL -- requirements
Module: ddmtd_meas_ctrl

Interface
REQ-001 Parameter TAG_W, default 16, width of one phase tag in DDMTD clock cycles.
REQ-002 Parameter MAX_AVG_LOG2, default 8, maximum log2 of the measurement count per run.
REQ-003 Parameter RST_CYCLES, default 4, number of cycles the sampler reset is held low per run.
REQ-004 Parameter SETTLE_CYCLES, default 16, wait after sampler reset release before edge detection.
REQ-005 clk_ddmtd_i  in  1  DDMTD sampling clock; the only clock of the block.
REQ-006 rst_ddmtdclk_i  in  1  synchronous, active-high reset.
REQ-007 start_i  in  1  one-cycle request to begin a measurement run.
REQ-008 n_avg_i  in  4  log2 of the number of tags to accumulate; captured at start.
REQ-009 clk_a_sampled_i  in  1  sampled reference clock from sampler A.
REQ-010 clk_b_sampled_i  in  1  sampled target clock from sampler B.
REQ-011 sampler_rst_n_o  out  1  active-low reset driven to both samplers.
REQ-012 busy_o  out  1  high from the cycle after an accepted start until done_o.
REQ-013 done_o  out  1  one-cycle pulse at the end of a run.
REQ-014 err_o  out  1  run ended on timeout; valid with done_o, held until next accepted start.
REQ-015 phase_sum_o  out  TAG_W+MAX_AVG_LOG2  accumulated tag sum; held until next accepted start.
REQ-016 phase_avg_o  out  TAG_W  phase_sum_o shifted right by the captured n_avg; held likewise.

Function
REQ-017 FSM states SHALL be IDLE, SRST, SETTLE, ARM_A, WAIT_B, NEXT, DONE.
REQ-018 IDLE: start_i=1 SHALL go to SRST, clear sum/err, capture n_avg = min(n_avg_i, MAX_AVG_LOG2), zero the measurement count.
REQ-019 start_i outside IDLE SHALL be ignored.
REQ-020 SRST: sampler_rst_n_o=0 for exactly RST_CYCLES cycles, then SETTLE; sampler_rst_n_o=1 in all other non-reset states.
REQ-021 SETTLE: exactly SETTLE_CYCLES cycles, then ARM_A.
REQ-022 Edge detect: each input registered once (prev); edge = input & ~prev; prev registers forced to 1 in reset, SRST and SETTLE so no edge is reported from sampler reset release.
REQ-023 ARM_A: on edge_a go to WAIT_B with tag counter = 0; if edge_b occurs in the same cycle, tag = 0 is taken immediately and the state goes to NEXT.
REQ-024 WAIT_B: tag counter increments by 1 each cycle; on edge_b the tag = counter value + 1 (cycles from A edge to B edge), go to NEXT.
REQ-025 NEXT: sum += tag (zero-extended); count += 1; if count == 2^n_avg go to DONE, else ARM_A (1 cycle).
REQ-026 Timeout: a counter SHALL run in ARM_A and WAIT_B, cleared on each state entry; at 2^TAG_W-1 without the awaited edge, set err_o=1 and go to DONE; sum retains partial value.
REQ-027 DONE: done_o=1 for one cycle, phase_avg_o updated the same cycle, then IDLE.
REQ-028 Sum SHALL NOT wrap: width TAG_W+MAX_AVG_LOG2 covers 2^MAX_AVG_LOG2 maximal tags.
REQ-029 Edges in IDLE, SRST, SETTLE, NEXT, DONE SHALL be ignored.

Reset
REQ-030 On rst_ddmtdclk_i=1 at a clock edge: state IDLE, sampler_rst_n_o=0, busy_o=0, done_o=0, err_o=0, phase_sum_o=0, phase_avg_o=0, all counters 0, prev registers 1.
REQ-031 Reset asserted mid-run SHALL abort the run with no done_o pulse; sampler_rst_n_o returns to 1 the first cycle after reset deasserts.

Verification
REQ-032 Reset then start_i, n_avg_i=0, A rises, B rises 5 cycles later -> sampler_rst_n_o low 4 cycles, busy_o, done_o pulse, phase_sum_o=5, phase_avg_o=5, err_o=0.
REQ-033 n_avg_i=2, B lags A by 10,12,10,12 cycles -> phase_sum_o=44, phase_avg_o=11, exactly one done_o.
REQ-034 A and B rise in the same cycle, n_avg_i=0 -> phase_sum_o=0, err_o=0.
REQ-035 A toggles, B held low, TAG_W=8 -> done_o and err_o=1 after 255 cycles in WAIT_B.
REQ-036 n_avg_i=15 with MAX_AVG_LOG2=8 -> exactly 256 tags accumulated; start_i pulsed while busy_o -> no effect.
REQ-037 Reset asserted in WAIT_B -> no done_o, outputs at reset values, next start_i runs normally.
